// File: rtl/store_merge_unit.sv
// rtl/store_merge_unit.sv - read-modify-write store merger for the word-only data memory
module store_merge_unit #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  st_valid,
   output logic                  st_ready,
   input  logic [DM_ADDRESS-1:0] a,
   input  logic [DATA_W-1:0]     wd,
   input  logic [2:0]            Funct3,
   output logic                  busy,
   output logic                  st_done,
   output logic                  st_err,
   output logic [DM_ADDRESS-1:0] mem_raddr,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic [DM_ADDRESS-1:0] mem_waddr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic                  mem_wr
);

   typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

   state_t                state_q, state_d;
   logic [DM_ADDRESS-1:0] addr_q, addr_d;
   logic [15:0]           lane_q, lane_d;   // only the low halfword of wd is ever merged
   logic [2:0]            f3_q, f3_d;
   logic [DATA_W-1:0]     word_q, word_d;   // word to be written in WRITE
   logic                  err_q, err_d;
   logic                  accept;
   logic                  legal;

   // Request acceptance and legality of the incoming store (alignment per size)
   always_comb begin
      accept = st_valid && (state_q == IDLE);
      legal  = 1'b0;
      case (Funct3)
         3'b000:  legal = 1'b1;
         3'b001:  legal = !a[0];
         3'b010:  legal = (a[1:0] == 2'b00);
         default: legal = 1'b0;
      endcase
   end

   // Next-state, latch capture and lane merge
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      lane_d  = lane_q;
      f3_d    = f3_q;
      word_d  = word_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               addr_d = a;
               lane_d = wd[15:0];
               f3_d   = Funct3;
               if (!legal) begin
                  err_d = 1'b1;
               end else if (Funct3 == 3'b010) begin
                  word_d  = wd;
                  state_d = WRITE;
               end else begin
                  state_d = READ;
               end
            end
         end
         READ: begin
            // Old word arrives now because mem_raddr was presented during the accept cycle
            word_d = mem_rdata;
            if (f3_q == 3'b000) begin
               word_d[{addr_q[1:0], 3'b000} +: 8] = lane_q[7:0];
            end else begin
               word_d[{addr_q[1], 4'b0000} +: 16] = lane_q;
            end
            state_d = WRITE;
         end
         WRITE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and latch registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         lane_q  <= '0;
         f3_q    <= '0;
         word_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         lane_q  <= lane_d;
         f3_q    <= f3_d;
         word_q  <= word_d;
         err_q   <= err_d;
      end
   end

   // Outputs; the write strobe is killed by reset so an aborted store never lands
   always_comb begin
      st_ready  = (state_q == IDLE);
      busy      = !st_ready;
      st_err    = err_q;
      mem_wr    = (state_q == WRITE) && !reset;
      st_done   = mem_wr;
      mem_waddr = {addr_q[DM_ADDRESS-1:2], 2'b00};
      mem_wdata = word_q;
      if (reset) begin
         mem_raddr = '0;
      end else if (state_q == IDLE) begin
         mem_raddr = {a[DM_ADDRESS-1:2], 2'b00};
      end else begin
         mem_raddr = {addr_q[DM_ADDRESS-1:2], 2'b00};
      end
   end

endmodule

// File: tb/tb_store_merge_unit.sv
// tb/tb_store_merge_unit.sv - self-checking bench for store_merge_unit
module tb_store_merge_unit;

   logic        clk;
   logic        reset;
   logic        st_valid;
   logic        st_ready;
   logic [8:0]  a;
   logic [31:0] wd;
   logic [2:0]  Funct3;
   logic        busy;
   logic        st_done;
   logic        st_err;
   logic [8:0]  mem_raddr;
   logic [31:0] mem_rdata;
   logic [8:0]  mem_waddr;
   logic [31:0] mem_wdata;
   logic        mem_wr;

   logic [31:0] mem [0:127];
   logic        pl_en;
   logic [6:0]  pl_idx;
   logic [31:0] pl_data;

   int checks;
   int errors;
   logic [40:0] sb_q [$];

   typedef struct {
      logic [2:0]  f3;
      logic [8:0]  addr;
      logic [31:0] data;
      bit          init_en;
      logic [31:0] init;
      bit          err;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [13];

   store_merge_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .st_valid  (st_valid),
      .st_ready  (st_ready),
      .a         (a),
      .wd        (wd),
      .Funct3    (Funct3),
      .busy      (busy),
      .st_done   (st_done),
      .st_err    (st_err),
      .mem_raddr (mem_raddr),
      .mem_rdata (mem_rdata),
      .mem_waddr (mem_waddr),
      .mem_wdata (mem_wdata),
      .mem_wr    (mem_wr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word memory: registered read, write at the edge ending the mem_wr cycle
   always @(posedge clk) begin
      if (pl_en) mem[pl_idx] <= pl_data;
      else if (mem_wr) mem[mem_waddr[8:2]] <= mem_wdata;
      mem_rdata <= mem[mem_raddr[8:2]];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [6:0] idx, input logic [31:0] data);
      @(negedge clk);
      pl_en = 1'b1; pl_idx = idx; pl_data = data;
      @(posedge clk);
      #1 pl_en = 1'b0;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      @(negedge clk);
      while (!st_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", {31'd0, st_ready}, 32'd1);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      if (v.init_en) preload(v.addr[8:2], v.init);
      wait_ready();
      if (!v.err) sb_q.push_back({v.addr[8:2], 2'b00, v.exp});
      st_valid = 1'b1; Funct3 = v.f3; a = v.addr; wd = v.data;
      @(posedge clk);
      #1 st_valid = 1'b0;
      @(negedge clk);
      if (v.err) begin
         chk($sformatf("v%0d_err_c1", idx), {29'd0, st_err, st_ready, mem_wr}, 32'b110);
         @(negedge clk);
         chk($sformatf("v%0d_err_pulse", idx), {31'd0, st_err}, 32'd0);
      end else if (v.f3 == 3'b010) begin
         chk($sformatf("v%0d_sw_wr_c1", idx), {31'd0, mem_wr}, 32'd1);
         @(negedge clk);
         chk($sformatf("v%0d_sw_ready_c2", idx), {31'd0, st_ready}, 32'd1);
      end else begin
         chk($sformatf("v%0d_read_c1", idx), {30'd0, busy, mem_wr}, 32'b10);
         @(negedge clk);
         chk($sformatf("v%0d_wr_c2", idx), {31'd0, mem_wr}, 32'd1);
         @(negedge clk);
         chk($sformatf("v%0d_ready_c3", idx), {31'd0, st_ready}, 32'd1);
      end
      chk($sformatf("v%0d_mem", idx), mem[v.addr[8:2]], v.exp);
   endtask

   initial begin
      logic [40:0] e;
      logic        prev_wr;
      checks = 0; errors = 0;
      reset = 1'b1; st_valid = 1'b0; a = '0; wd = '0; Funct3 = '0;
      pl_en = 1'b0; pl_idx = '0; pl_data = '0;
      prev_wr = 1'b0;

      //          f3      addr    data          init  init_val      err   expected word
      vecs[0]  = '{3'b010, 9'h010, 32'hDEADBEEF, 1'b1, 32'h00000000, 1'b0, 32'hDEADBEEF};
      vecs[1]  = '{3'b000, 9'h022, 32'h000000AA, 1'b1, 32'h11223344, 1'b0, 32'h11AA3344};
      vecs[2]  = '{3'b000, 9'h023, 32'h000000BB, 1'b0, 32'h0,        1'b0, 32'hBBAA3344};
      vecs[3]  = '{3'b001, 9'h032, 32'h0000CAFE, 1'b1, 32'h12345678, 1'b0, 32'hCAFE5678};
      vecs[4]  = '{3'b001, 9'h031, 32'h00001111, 1'b0, 32'h0,        1'b1, 32'hCAFE5678};
      vecs[5]  = '{3'b011, 9'h040, 32'h99999999, 1'b1, 32'h55555555, 1'b1, 32'h55555555};
      vecs[6]  = '{3'b000, 9'h040, 32'h12345677, 1'b0, 32'h0,        1'b0, 32'h55555577};
      vecs[7]  = '{3'b000, 9'h041, 32'hFFFFFF88, 1'b0, 32'h0,        1'b0, 32'h55558877};
      vecs[8]  = '{3'b001, 9'h040, 32'hFFFF1234, 1'b0, 32'h0,        1'b0, 32'h55551234};
      vecs[9]  = '{3'b010, 9'h042, 32'h0BADF00D, 1'b0, 32'h0,        1'b1, 32'h55551234};
      vecs[10] = '{3'b010, 9'h1FC, 32'hA5A5A5A5, 1'b1, 32'h00000000, 1'b0, 32'hA5A5A5A5};
      vecs[11] = '{3'b111, 9'h044, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b1, 32'h00000000};
      vecs[12] = '{3'b001, 9'h1FE, 32'h0000BEEF, 1'b1, 32'h00000000, 1'b0, 32'hBEEF0000};

      // Write monitor: every strobe must match the scoreboard head, last one cycle, coincide with st_done
      fork
         forever begin
            @(negedge clk);
            if (mem_wr || st_done) begin
               chk("done_eq_wr", {31'd0, st_done}, {31'd0, mem_wr});
               if (sb_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_write: addr 0x%03h data 0x%08h, none required", mem_waddr, mem_wdata);
               end else begin
                  e = sb_q.pop_front();
                  chk("wr_addr", {23'd0, mem_waddr}, {23'd0, e[40:32]});
                  chk("wr_data", mem_wdata, e[31:0]);
               end
            end
            if (mem_wr && prev_wr) begin
               checks++; errors++;
               $display("FAIL wr_width: mem_wr high 2 cycles, required 1");
            end
            prev_wr = mem_wr;
         end
      join_none

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {27'd0, st_ready, busy, mem_wr, st_done, st_err}, 32'b10000);
      @(posedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

      // st_valid held while busy: second SB to the same word waits and reads the updated word
      preload(7'h14, 32'h0);
      wait_ready();
      sb_q.push_back({9'h050, 32'h00000011});
      sb_q.push_back({9'h050, 32'h00002211});
      st_valid = 1'b1; Funct3 = 3'b000; a = 9'h050; wd = 32'h11;
      @(posedge clk);
      #1 a = 9'h051; wd = 32'h22;
      @(negedge clk);
      chk("hold_busy_c1", {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk("hold_busy_c2", {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk("hold_ready_c3", {31'd0, st_ready}, 32'd1);
      @(posedge clk);
      #1 st_valid = 1'b0;
      @(negedge clk);
      chk("hold2_busy_c1", {30'd0, busy, mem_wr}, 32'b10);
      @(negedge clk);
      chk("hold2_wr_c2", {31'd0, mem_wr}, 32'd1);
      @(negedge clk);
      chk("hold_mem", mem[7'h14], 32'h00002211);

      // Reset during READ of an SB
      preload(7'h18, 32'hCAFEBABE);
      wait_ready();
      st_valid = 1'b1; Funct3 = 3'b000; a = 9'h061; wd = 32'h77;
      @(posedge clk);
      #1 st_valid = 1'b0; reset = 1'b1;
      @(negedge clk);
      chk("rst_read_nowr", {31'd0, mem_wr}, 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_read_idle", {29'd0, st_ready, busy, mem_wr}, 32'b100);
      @(negedge clk);
      chk("rst_read_mem", mem[7'h18], 32'hCAFEBABE);

      // Reset during WRITE of an SW
      preload(7'h19, 32'h0);
      wait_ready();
      st_valid = 1'b1; Funct3 = 3'b010; a = 9'h064; wd = 32'h12345678;
      @(posedge clk);
      #1 st_valid = 1'b0; reset = 1'b1;
      @(negedge clk);
      chk("rst_write_nowr", {30'd0, mem_wr, st_done}, 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_write_idle", {30'd0, st_ready, busy}, 32'b10);
      @(negedge clk);
      chk("rst_write_mem", mem[7'h19], 32'h0);

      chk("sb_empty", sb_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
